// File: rtl/j_uart_ctl_if.sv
// Register-bus handshake between the GPU/DSP host and the UART2 controller.
interface j_uart_ctl_if;
  logic [1:0]  addr;
  logic        wr;
  logic        rd;
  logic [15:0] din;
  logic [15:0] dout;
  logic        dout_vld;

  modport master (output addr, wr, rd, din, input dout, dout_vld);
  modport slave  (input addr, wr, rd, din, output dout, dout_vld);
endinterface

// File: rtl/j_uart_ctl.sv
// UART2 host-side controller: baud divisor, CTRL/STAT registers, strobes and irq.
// Optional loopback (CTRL[9], STAT[12]) built only when J_UART_LOOPBACK_EN is defined.
module j_uart_ctl #(
  parameter int               DIV_W   = 16,
  parameter logic [DIV_W-1:0] RST_DIV = '0
) (
  input  logic       clk,
  input  logic       resetl,
  j_uart_ctl_if.slave bus,
  input  logic [7:0] rx_dr,
  input  logic       rbf,
  input  logic       pe,
  input  logic       oe,
  input  logic       fe,
  input  logic       tbe,
  output logic       bx16,
  output logic       paren,
  output logic       even,
  output logic       rxpol,
  output logic       txpol,
  output logic       txbrk,
  output logic       clr_err,
  output logic       u2drd,
  output logic       tx_ld,
  output logic [7:0] tx_data,
  input  logic       serin_pad,
  output logic       serin_rx,
  input  logic       serout_tx,
  output logic       serout_pad,
  output logic       irq
);

  localparam logic [1:0] A_DATA = 2'd0;
  localparam logic [1:0] A_CTRL = 2'd1;
  localparam logic [1:0] A_DIV  = 2'd2;

  logic [5:0]       ctrl_lo;
  logic             brk_q;
  logic             loop;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] cnt_q;
  logic             rbf_q, err_q, tbe_q;
  logic             err;
  logic             wr_data, wr_ctrl, wr_div;
  logic             irq_set, irq_ack;
  logic [15:0]      stat;
  logic [15:0]      rd_mux;

  assign err     = pe | oe | fe;
  assign wr_data = bus.wr && (bus.addr == A_DATA);
  assign wr_ctrl = bus.wr && (bus.addr == A_CTRL);
  assign wr_div  = bus.wr && (bus.addr == A_DIV);

  // ---------------- control register ----------------
  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) begin
      ctrl_lo <= '0;
      brk_q   <= 1'b0;
    end else if (wr_ctrl) begin
      ctrl_lo <= bus.din[5:0];
      brk_q   <= bus.din[8];
    end
  end

`ifdef J_UART_LOOPBACK_EN
  logic loop_q;
  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl)      loop_q <= 1'b0;
    else if (wr_ctrl) loop_q <= bus.din[9];
  end
  assign loop = loop_q;
  logic unused_din;
  assign unused_din = ^bus.din[15:10];
`else
  assign loop = 1'b0;
  logic unused_din;
  assign unused_din = ^bus.din[15:9];
`endif

  assign even  = ~ctrl_lo[0];
  assign paren = ctrl_lo[1];
  assign txpol = ctrl_lo[2];
  assign rxpol = ctrl_lo[3];
  assign txbrk = brk_q;

  // Loopback feeds the transmitter back in and parks the pad at its idle level.
  assign serin_rx   = loop ? serout_tx : serin_pad;
  assign serout_pad = loop ? ~ctrl_lo[2] : serout_tx;

  // ---------------- baud divisor ----------------
  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) begin
      div_q <= RST_DIV;
      cnt_q <= '0;
      bx16  <= 1'b0;
    end else if (wr_div) begin
      div_q <= bus.din[DIV_W-1:0];
      cnt_q <= bus.din[DIV_W-1:0];
      bx16  <= 1'b0;
    end else if (div_q == '0) begin
      cnt_q <= '0;
      bx16  <= 1'b0;
    end else if (cnt_q == '0) begin
      cnt_q <= div_q;
      bx16  <= 1'b1;
    end else begin
      cnt_q <= cnt_q - 1'b1;
      bx16  <= 1'b0;
    end
  end

  // ---------------- read path ----------------
  always_comb begin
    stat       = '0;
    stat[15]   = err;
    stat[14]   = brk_q;
    stat[13]   = serin_pad;
    stat[12]   = loop;
    stat[11]   = oe;
    stat[10]   = fe;
    stat[9]    = pe;
    stat[8]    = tbe;
    stat[7]    = rbf;
    stat[5:0]  = ctrl_lo;
  end

  always_comb begin
    rd_mux = '0;
    case (bus.addr)
      A_DATA:  rd_mux = {8'h00, rx_dr};
      A_CTRL:  rd_mux = stat;
      A_DIV:   rd_mux[DIV_W-1:0] = div_q;
      default: rd_mux = '0;
    endcase
  end

  // rd_mux samples pre-write state, so a same-cycle write never leaks into the read.
  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) begin
      bus.dout     <= '0;
      bus.dout_vld <= 1'b0;
      u2drd        <= 1'b0;
    end else begin
      bus.dout_vld <= bus.rd;
      u2drd        <= bus.rd && (bus.addr == A_DATA);
      if (bus.rd) bus.dout <= rd_mux;
    end
  end

  // ---------------- strobes to datapath ----------------
  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) begin
      tx_data <= '0;
      tx_ld   <= 1'b0;
      clr_err <= 1'b0;
    end else begin
      tx_ld   <= wr_data;
      clr_err <= wr_ctrl && bus.din[6];
      if (wr_data) tx_data <= bus.din[7:0];
    end
  end

  // ---------------- interrupt ----------------
  assign irq_set = (ctrl_lo[5] && rbf && !rbf_q)
                 | (ctrl_lo[5] && err && !err_q)
                 | (ctrl_lo[4] && tbe && !tbe_q);
  assign irq_ack = wr_ctrl && bus.din[7];

  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) begin
      rbf_q <= 1'b0;
      err_q <= 1'b0;
      tbe_q <= 1'b0;
      irq   <= 1'b0;
    end else begin
      rbf_q <= rbf;
      err_q <= err;
      tbe_q <= tbe;
      irq   <= irq_set | (irq & ~irq_ack);
    end
  end

endmodule

// File: tb/tb_j_uart_ctl.sv
// Scoreboarded bench for j_uart_ctl: reads push expected data, dout_vld pops it.
module tb_j_uart_ctl;
  logic       clk = 1'b0;
  logic       resetl;
  logic [7:0] rx_dr;
  logic       rbf, pe, oe, fe, tbe;
  logic       bx16, paren, even, rxpol, txpol, txbrk;
  logic       clr_err, u2drd, tx_ld;
  logic [7:0] tx_data;
  logic       serin_pad, serin_rx, serout_tx, serout_pad, irq;

  j_uart_ctl_if bus ();

  j_uart_ctl dut (
    .clk(clk), .resetl(resetl), .bus(bus.slave),
    .rx_dr(rx_dr), .rbf(rbf), .pe(pe), .oe(oe), .fe(fe), .tbe(tbe),
    .bx16(bx16), .paren(paren), .even(even), .rxpol(rxpol), .txpol(txpol),
    .txbrk(txbrk), .clr_err(clr_err), .u2drd(u2drd), .tx_ld(tx_ld),
    .tx_data(tx_data), .serin_pad(serin_pad), .serin_rx(serin_rx),
    .serout_tx(serout_tx), .serout_pad(serout_pad), .irq(irq)
  );

  always #5 clk = ~clk;

`ifdef J_UART_LOOPBACK_EN
  localparam logic [15:0] CTRL_MASK = 16'h033F;
`else
  localparam logic [15:0] CTRL_MASK = 16'h013F;
`endif

  int          n_chk = 0;
  int          n_err = 0;
  logic [15:0] sb[$];
  logic [15:0] ctrl_sh;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] stat_exp();
    logic [15:0] s;
    s       = '0;
    s[15]   = pe | oe | fe;
    s[14]   = ctrl_sh[8];
    s[13]   = serin_pad;
    s[12]   = ctrl_sh[9];
    s[11]   = oe;
    s[10]   = fe;
    s[9]    = pe;
    s[8]    = tbe;
    s[7]    = rbf;
    s[5:0]  = ctrl_sh[5:0];
    return s;
  endfunction

  always @(negedge clk) begin
    if (bus.dout_vld) begin
      if (sb.size() == 0) chk("rd_spurious", 1, 0);
      else                chk("rd_data", bus.dout, sb.pop_front());
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [15:0] d);
    bus.addr = a; bus.din = d; bus.wr = 1'b1;
    step(1);
    bus.wr = 1'b0;
  endtask

  task automatic bus_rd(input logic [1:0] a, input logic [15:0] exp);
    sb.push_back(exp);
    bus.addr = a; bus.rd = 1'b1;
    step(1);
    bus.rd = 1'b0;
  endtask

  task automatic wr_ctrl(input logic [15:0] d);
    bus_wr(2'd1, d);
    ctrl_sh = d & CTRL_MASK;
  endtask

  initial begin
    logic [19:0] obs, expv;
    int          cnt;

    resetl = 1'b0; bus.addr = '0; bus.wr = 1'b0; bus.rd = 1'b0; bus.din = '0;
    rx_dr = '0; rbf = 0; pe = 0; oe = 0; fe = 0; tbe = 0;
    serin_pad = 1'b0; serout_tx = 1'b1; ctrl_sh = '0;
    step(2);
    chk("rst_dout", bus.dout, 0);
    chk("rst_vld", bus.dout_vld, 0);
    chk("rst_bx16", bx16, 0);
    chk("rst_irq", irq, 0);
    chk("rst_strobes", {clr_err, u2drd, tx_ld}, 0);
    chk("rst_tx_data", tx_data, 0);
    resetl = 1'b1;
    step(1);

    // Baud tick with DIV=3 and DIV=1, then disabled with DIV=0
    bus_wr(2'd2, 16'd3);
    for (int i = 1; i <= 20; i++) begin
      step(1);
      obs[i-1]  = bx16;
      expv[i-1] = (i % 4 == 0);
    end
    chk("bx16_div3", obs, expv);
    bus_rd(2'd2, 16'd3);
    bus_wr(2'd2, 16'd1);
    for (int i = 1; i <= 20; i++) begin
      step(1);
      obs[i-1]  = bx16;
      expv[i-1] = (i % 2 == 0);
    end
    chk("bx16_div1", obs, expv);
    bus_wr(2'd2, 16'd0);
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      step(1);
      cnt += int'(bx16);
    end
    chk("bx16_div0", cnt, 0);

    // CTRL / STAT
    rbf = 1; pe = 1;
    step(1);
    wr_ctrl(16'h0003);
    chk("cfg_even_paren", {even, paren}, 2'b01);
    bus_rd(2'd1, 16'h8283);
    chk("stat_no_u2drd", u2drd, 0);
    wr_ctrl(16'h0023);
    bus_rd(2'd1, stat_exp());

    // DATA read strobe
    rx_dr = 8'hA5;
    bus_rd(2'd0, 16'h00A5);
    chk("u2drd_hi", u2drd, 1);
    step(1);
    chk("u2drd_lo", u2drd, 0);

    // Error clear pulse, bit 6 not retained
    wr_ctrl(16'h0063);
    chk("clr_err_hi", clr_err, 1);
    step(1);
    chk("clr_err_lo", clr_err, 0);
    bus_rd(2'd1, stat_exp());

    // Interrupt: rbf edge, hold, ack, set-wins, tbe edge
    rbf = 0; pe = 0;
    step(2);
    chk("irq_idle", irq, 0);
    rbf = 1;
    step(2);
    chk("irq_rbf", irq, 1);
    step(3);
    chk("irq_sticky", irq, 1);
    wr_ctrl(16'h00A3);
    chk("irq_ack", irq, 0);
    step(4);
    chk("irq_no_rearm", irq, 0);
    rbf = 0; pe = 1;
    step(2);
    chk("irq_err", irq, 1);
    rbf = 1;
    wr_ctrl(16'h00A3);
    chk("irq_set_wins", irq, 1);
    step(1);
    wr_ctrl(16'h00A3);
    chk("irq_ack2", irq, 0);
    wr_ctrl(16'h0013);
    tbe = 1;
    step(2);
    chk("irq_tbe", irq, 1);

    // Asynchronous reset mid-count
    bus_wr(2'd2, 16'd5);
    bus_rd(2'd1, stat_exp());
    step(3);
    #2 resetl = 1'b0;
    #1;
    chk("arst_bx16", bx16, 0);
    chk("arst_irq", irq, 0);
    chk("arst_dout", bus.dout, 0);
    step(1);
    resetl = 1'b1; ctrl_sh = '0;
    step(1);

    // Transmit load
    bus_wr(2'd0, 16'h003C);
    chk("tx_data", tx_data, 8'h3C);
    chk("tx_ld_hi", tx_ld, 1);
    step(1);
    chk("tx_ld_lo", tx_ld, 0);

    // Read and write together: read sees pre-write CTRL
    sb.push_back(stat_exp());
    bus.addr = 2'd1; bus.din = 16'h0003; bus.wr = 1'b1; bus.rd = 1'b1;
    step(1);
    bus.wr = 1'b0; bus.rd = 1'b0; ctrl_sh = 16'h0003;
    bus_rd(2'd1, stat_exp());

    // Serial pin routing
    wr_ctrl(16'h0200);
`ifdef J_UART_LOOPBACK_EN
    serin_pad = 1; serout_tx = 0; #1;
    chk("loop_rx0", serin_rx, 0);
    chk("loop_pad0", serout_pad, 1);
    serin_pad = 0; serout_tx = 1; #1;
    chk("loop_rx1", serin_rx, 1);
    chk("loop_pad1", serout_pad, 1);
`else
    serin_pad = 1; serout_tx = 0; #1;
    chk("pass_rx1", serin_rx, 1);
    chk("pass_pad0", serout_pad, 0);
    serin_pad = 0; serout_tx = 1; #1;
    chk("pass_rx0", serin_rx, 0);
    chk("pass_pad1", serout_pad, 1);
`endif
    bus_rd(2'd1, stat_exp());

    step(3);
    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_err);
    $finish;
  end
endmodule
